// File: rtl/ps2_scancode_receiver.sv
// PS/2 keyboard receiver: delivers make scan codes on `character`, filtering break (F0) and extended (E0) sequences.
// Optional KEY_RELEASE_CLEAR_EN: releasing the displayed key clears `character` to 8'h00.
module ps2_scancode_receiver #(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       Pixelclock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] character,
  output logic       char_valid,
  output logic       frame_error,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sr, data_sr;
  logic ps2_clk_sync, ps2_clk_sync_d, ps2_data_sync, fall;

  // Synchronisers idle high so reset release never fakes a falling edge.
  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      clk_sr         <= '1;
      data_sr        <= '1;
      ps2_clk_sync_d <= 1'b1;
    end else begin
      clk_sr         <= {clk_sr[SYNC_STAGES-2:0], ps2_clk};
      data_sr        <= {data_sr[SYNC_STAGES-2:0], ps2_data};
      ps2_clk_sync_d <= ps2_clk_sync;
    end
  end

  assign ps2_clk_sync  = clk_sr[SYNC_STAGES-1];
  assign ps2_data_sync = data_sr[SYNC_STAGES-1];
  assign fall          = ps2_clk_sync_d & ~ps2_clk_sync;

  state_t        state, state_n;
  logic [7:0]    shift, shift_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [CW-1:0] tcnt, tcnt_n, tcnt_inc;
  logic          parity, parity_n;
  logic          break_pending, break_n;
  logic          ext_pending, ext_n;
  logic [7:0]    char_n;
  logic          cv_n, fe_n;

  assign tcnt_inc = tcnt + CW'(1);

  always_ff @(posedge Pixelclock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shift         <= '0;
      bit_cnt       <= '0;
      tcnt          <= '0;
      parity        <= 1'b0;
      break_pending <= 1'b0;
      ext_pending   <= 1'b0;
      character     <= 8'h00;
      char_valid    <= 1'b0;
      frame_error   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      shift         <= shift_n;
      bit_cnt       <= bit_cnt_n;
      tcnt          <= tcnt_n;
      parity        <= parity_n;
      break_pending <= break_n;
      ext_pending   <= ext_n;
      character     <= char_n;
      char_valid    <= cv_n;
      frame_error   <= fe_n;
      busy          <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n   = state;
    shift_n   = shift;
    bit_cnt_n = bit_cnt;
    tcnt_n    = tcnt;
    parity_n  = parity;
    break_n   = break_pending;
    ext_n     = ext_pending;
    char_n    = character;
    cv_n      = 1'b0;
    fe_n      = 1'b0;

    case (state)
      IDLE: begin
        tcnt_n = '0;
        if (fall && !ps2_data_sync) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: if (fall) begin
        shift_n   = {ps2_data_sync, shift[7:1]};
        bit_cnt_n = bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) state_n = PARITY;
      end
      PARITY: if (fall) begin
        parity_n = ps2_data_sync;
        state_n  = STOP;
      end
      STOP: if (fall) begin
        state_n = IDLE;
        if (!(^{shift, parity}) || !ps2_data_sync) begin
          fe_n    = 1'b1;
          break_n = 1'b0;
          ext_n   = 1'b0;
        end else if (shift == 8'hF0) begin
          break_n = 1'b1;
        end else if (shift == 8'hE0) begin
          ext_n = 1'b1;
        end else if (break_pending) begin
          break_n = 1'b0;
          ext_n   = 1'b0;
`ifdef KEY_RELEASE_CLEAR_EN
          if (shift == character) begin
            char_n = 8'h00;
            cv_n   = 1'b1;
          end
`endif
        end else if (ext_pending) begin
          ext_n = 1'b0;
        end else begin
          char_n = shift;
          cv_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Inside a frame: a fall restarts the gap timer and wins over terminal count.
    if (state != IDLE) begin
      if (fall) begin
        tcnt_n = '0;
      end else if (tcnt_inc == TC_LAST) begin
        state_n = IDLE;
        fe_n    = 1'b1;
        shift_n = '0;
        tcnt_n  = '0;
      end else begin
        tcnt_n = tcnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// Directed bench for ps2_scancode_receiver: frames, filtering, parity error, timeout and mid-frame reset.
module tb_ps2_scancode_receiver;

  logic       Pixelclock = 1'b0;
  logic       reset      = 1'b1;
  logic       ps2_clk    = 1'b1;
  logic       ps2_data   = 1'b1;
  logic [7:0] character;
  logic       char_valid, frame_error, busy;

  int checks = 0;
  int errors = 0;
  int cv_cnt = 0, fe_cnt = 0, both_cnt = 0;
  int cv0, fe0;

  ps2_scancode_receiver dut (
    .Pixelclock (Pixelclock),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .character  (character),
    .char_valid (char_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #20 Pixelclock = ~Pixelclock;

  always @(negedge Pixelclock) begin
    if (!reset) begin
      if (char_valid) cv_cnt++;
      if (frame_error) fe_cnt++;
      if (char_valid && frame_error) both_cnt++;
    end
  end

  initial begin
    #20ms;
    $display("FAIL watchdog: observed no completion, expected finish before 20 ms");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge Pixelclock);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
    wait_cyc(10);
  endtask

  // Full 11-bit frame; parity is odd unless par_ok=0. lat_check probes output timing on the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic lat_check);
    logic par;
    par = (~^b) ^ ~par_ok;
    send_bit(1'b0);
    if (lat_check) chk("busy_mid_frame", busy, 1);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    ps2_data = 1'b1;
    wait_cyc(10);
    ps2_clk = 1'b0;
    if (lat_check) begin
      wait_cyc(2);
      chk("lat_cv_early", char_valid, 0);
      wait_cyc(1);
      chk("lat_cv_at_3", char_valid, 1);
      wait_cyc(1);
      chk("lat_cv_after", char_valid, 0);
      wait_cyc(16);
    end else begin
      wait_cyc(20);
    end
    ps2_clk = 1'b1;
    wait_cyc(10);
  endtask

  initial begin
    wait_cyc(5);
    chk("rst_character", character, 8'h00);
    chk("rst_char_valid", char_valid, 0);
    chk("rst_frame_error", frame_error, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    wait_cyc(5);

    // Single make code with latency probe
    cv0 = cv_cnt;
    send_frame(8'h2B, 1'b1, 1'b1);
    chk("2b_character", character, 8'h2b);
    chk("2b_cv_count", cv_cnt - cv0, 1);
    chk("2b_busy_after", busy, 0);

    // Make, break, release
    cv0 = cv_cnt;
    send_frame(8'h15, 1'b1, 1'b0);
    chk("15_character", character, 8'h15);
    send_frame(8'hF0, 1'b1, 1'b0);
    send_frame(8'h15, 1'b1, 1'b0);
`ifdef KEY_RELEASE_CLEAR_EN
    chk("release_character", character, 8'h00);
    chk("release_cv_count", cv_cnt - cv0, 2);
`else
    chk("release_character", character, 8'h15);
    chk("release_cv_count", cv_cnt - cv0, 1);
`endif

    // Parity error then recovery
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h33, 1'b0, 1'b0);
`ifdef KEY_RELEASE_CLEAR_EN
    chk("perr_character", character, 8'h00);
`else
    chk("perr_character", character, 8'h15);
`endif
    chk("perr_fe_count", fe_cnt - fe0, 1);
    chk("perr_cv_count", cv_cnt - cv0, 0);
    send_frame(8'h22, 1'b1, 1'b0);
    chk("22_character", character, 8'h22);
    chk("22_cv_count", cv_cnt - cv0, 1);

    // Timeout: start plus four data bits of 0x2B, then the clock stays high
    fe0 = fe_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    ps2_data = 1'b1;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
    wait_cyc(24981);
    chk("to_fe_before", frame_error, 0);
    chk("to_busy_before", busy, 1);
    wait_cyc(1);
    chk("to_fe_pulse", frame_error, 1);
    wait_cyc(1);
    chk("to_fe_after", frame_error, 0);
    chk("to_busy_after", busy, 0);
    chk("to_character", character, 8'h22);
    cv0 = cv_cnt;
    send_frame(8'h2B, 1'b1, 1'b0);
    chk("to_rx_character", character, 8'h2b);
    chk("to_rx_cv_count", cv_cnt - cv0, 1);
    chk("to_fe_count", fe_cnt - fe0, 1);

    // Extended prefix filtering
    send_frame(8'h15, 1'b1, 1'b0);
    cv0 = cv_cnt;
    send_frame(8'hE0, 1'b1, 1'b0);
    send_frame(8'h2B, 1'b1, 1'b0);
    chk("ext_character", character, 8'h15);
    chk("ext_cv_count", cv_cnt - cv0, 0);
    send_frame(8'h2B, 1'b1, 1'b0);
    chk("post_ext_character", character, 8'h2b);
    chk("post_ext_cv_count", cv_cnt - cv0, 1);

    // Reset during data bit 5
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    ps2_data = 1'b0;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(5);
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("midrst_character", character, 8'h00);
    chk("midrst_busy", busy, 0);
    chk("midrst_cv", char_valid, 0);
    chk("midrst_fe", frame_error, 0);
    wait_cyc(5);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(5);
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h15, 1'b1, 1'b0);
    chk("after_rst_character", character, 8'h15);
    chk("after_rst_cv_count", cv_cnt - cv0, 1);
    chk("after_rst_fe_count", fe_cnt - fe0, 0);
    chk("cv_fe_exclusive", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
